// File: rtl/ps2_key_rx.sv
// ps2_key_rx -- PS/2 keyboard receiver.
// Deserialises device-to-host frames taken straight from the ps2_clk/ps2_data
// pins and strips the E0 (extended) and F0 (break) prefixes. It reports:
//   key_p     one-cycle strobe, new make code on key_in (key_ext = E0 seen)
//   key_rel   one-cycle strobe, a break sequence completed (key_in untouched)
//   frame_err one-cycle strobe, bad start/parity/stop bit or inter-edge timeout
// Optional build macro: PS2_TYPEMATIC_SUPPRESS_EN
//   When defined, the block remembers the currently held key (code + ext) and
//   drops typematic repeats of that key until its break code arrives.
module ps2_key_rx #(
  parameter int TIMEOUT_CYCLES = 50000,  // clk cycles allowed between ps2_clk falls
  parameter int TO_W           = 16      // timeout counter width, 2**TO_W > TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       key_p,
  output logic       key_ext,
  output logic       key_rel,
  output logic       frame_err
);

  localparam logic [7:0]      CODE_EXT = 8'hE0;
  localparam logic [7:0]      CODE_BRK = 8'hF0;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronisation and ps2_clk falling-edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       fall;
  logic       data_s;

  // Two-flop synchronisers on both pins plus one history flop on the clock pin.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop in the block samples the values from before the edge.
    if (!resetn) begin
      // NOTE: synchronisers reset to 1 (idle bus) so leaving reset with the
      // pins idle can never look like a falling ps2_clk edge.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame FSM with inter-edge timeout
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            byte_ok;    // stop step with good parity and stop bit
  logic            bad_frame;  // stop step with bad parity or stop bit
  logic            timeout;    // inter-edge limit reached while mid-frame

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state logic: advance one bit per ps2_clk fall, otherwise run the timeout.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = to_cnt_q;
    byte_ok   = 1'b0;
    bad_frame = 1'b0;
    timeout   = 1'b0;

    if (fall) begin
      // A fall always wins over a timeout landing in the same cycle.
      to_cnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          // Odd parity: data bits plus parity bit hold an odd number of ones.
          if (data_s && (^shift_q ^ parity_q)) begin
            byte_ok = 1'b1;
          end else begin
            bad_frame = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        timeout  = 1'b1;
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_ONE;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte decoder: prefix tracking and output strobes
  // ---------------------------------------------------------------------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] key_in_q, key_in_d;
  logic       key_ext_q, key_ext_d;
  logic       key_p_q, key_p_d;
  logic       key_rel_q, key_rel_d;
  logic       frame_err_q, frame_err_d;

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  logic       held_valid_q, held_valid_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d;
  logic       held_match;

  // The incoming code (with the current ext prefix) names the held key.
  assign held_match = held_valid_q && (held_code_q == shift_q) && (held_ext_q == ext_q);
`endif

  // Decoder and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_in_q     <= '0;
      key_ext_q    <= 1'b0;
      key_p_q      <= 1'b0;
      key_rel_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
`endif
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_in_q     <= key_in_d;
      key_ext_q    <= key_ext_d;
      key_p_q      <= key_p_d;
      key_rel_q    <= key_rel_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
`endif
    end
  end

  // Interpret each accepted byte; byte_ok, bad_frame and timeout are mutually
  // exclusive, so at most one strobe can rise per cycle.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_in_d    = key_in_q;
    key_ext_d   = key_ext_q;
    key_p_d     = 1'b0;
    key_rel_d   = 1'b0;
    frame_err_d = bad_frame | timeout;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
`endif

    if (timeout) begin
      // An abandoned frame may have been part of a prefixed sequence.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        key_rel_d = 1'b1;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
        if (held_match) begin
          held_valid_d = 1'b0;
        end
`endif
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
        if (!held_match) begin
          key_in_d     = shift_q;
          key_ext_d    = ext_q;
          key_p_d      = 1'b1;
          held_valid_d = 1'b1;
          held_code_d  = shift_q;
          held_ext_d   = ext_q;
        end
`else
        key_in_d  = shift_q;
        key_ext_d = ext_q;
        key_p_d   = 1'b1;
`endif
      end
    end
  end

  assign key_in    = key_in_q;
  assign key_p     = key_p_q;
  assign key_ext   = key_ext_q;
  assign key_rel   = key_rel_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx -- self-checking bench for ps2_key_rx.
// Bit-bangs PS/2 frames onto the pins, records every strobe the DUT emits and
// compares the recorded list against a list predicted from the keyboard
// protocol rules (prefix handling, break codes, errors, timeouts, resets).
// Honours PS2_TYPEMATIC_SUPPRESS_EN the same way the design does.
`timescale 1ns/1ps
module tb_ps2_key_rx;

  localparam int TB_TO = 5000;  // shortened timeout keeps the run short

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  localparam int EXP_TYPEMATIC_MAKES = 2;
`else
  localparam int EXP_TYPEMATIC_MAKES = 4;
`endif

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_in;
  logic       key_p;
  logic       key_ext;
  logic       key_rel;
  logic       frame_err;

  always #10 clk = ~clk;  // 50 MHz

  ps2_key_rx #(
    .TIMEOUT_CYCLES(TB_TO),
    .TO_W          (13)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_in   (key_in),
    .key_p    (key_p),
    .key_ext  (key_ext),
    .key_rel  (key_rel),
    .frame_err(frame_err)
  );

  typedef enum int {EV_MAKE, EV_REL, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] code;  // key_in seen with the strobe
    logic       ext;   // key_ext seen with the strobe
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int t_fall  = 0;
  int overlap = 0;

  logic [7:0] pool [6] = '{8'h74, 8'h6b, 8'h1c, 8'h29, 8'h75, 8'h72};

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (int'(key_p) + int'(key_rel) + int'(frame_err) > 1) overlap <= overlap + 1;
      if (key_p)     got_q.push_back('{kind: EV_MAKE, code: key_in, ext: key_ext});
      if (key_rel)   got_q.push_back('{kind: EV_REL,  code: key_in, ext: key_ext});
      if (frame_err) got_q.push_back('{kind: EV_ERR,  code: key_in, ext: key_ext});
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #4ms;
    $display("FAIL watchdog: observed=no end of test expected=end within 4 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keyboard protocol as a list of expected strobes
  // ---------------------------------------------------------------------------
  logic       m_ext, m_brk;      // pending prefixes
  logic [7:0] m_code;            // code last reported as a make
  logic       m_kext;
  logic       m_held_v;          // key currently held down (typematic filter)
  logic [7:0] m_held_code;
  logic       m_held_ext;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_code = 8'h00; m_kext = 0;
    m_held_v = 0; m_held_code = 8'h00; m_held_ext = 0;
  endtask

  task automatic model_err();
    exp_q.push_back('{kind: EV_ERR, code: m_code, ext: m_kext});
  endtask

  task automatic model_timeout();
    model_err();
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit repeat_of_held;
    repeat_of_held = 0;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    repeat_of_held = m_held_v && (m_held_code == b) && (m_held_ext == m_ext);
`endif
    if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_brk) begin
        exp_q.push_back('{kind: EV_REL, code: m_code, ext: m_kext});
        if (repeat_of_held) m_held_v = 0;
      end else if (!repeat_of_held) begin
        m_code = b;
        m_kext = m_ext;
        exp_q.push_back('{kind: EV_MAKE, code: m_code, ext: m_kext});
        m_held_v = 1; m_held_code = b; m_held_ext = m_ext;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pin drivers
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    ps2_data = b;
    repeat (half - 1) @(negedge clk);
    ps2_clk = 1'b0;
    t_fall  = cyc;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; lat=1 also checks the key_p timing around the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit lat);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit(~(^b) ^ bad_par, half);
    if (lat) begin
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (half - 1) @(negedge clk);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      repeat (2) @(negedge clk);
      check("latency_edge2", key_p, 1'b0);
      @(negedge clk);
      check("latency_edge3", key_p, 1'b1);
      @(negedge clk);
      check("latency_one_cycle", key_p, 1'b0);
      repeat (half - 4) @(negedge clk);
      ps2_clk = 1'b1;
    end else begin
      send_bit(~bad_stop, half);
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int half);
    send_bit(1'b0, half);
    for (int i = 0; i < nbits; i++) send_bit(b[i], half);
  endtask

  task automatic send_key(input logic [7:0] b, input int half);
    send_frame(b, 0, 0, half, 0);
    model_byte(b);
  endtask

  // Hold ps2_clk high until len cycles after the last fall; optionally check
  // that frame_err first appears right at the timeout limit.
  task automatic stall(input int len, input bit chk_win, input string tag);
    int first;
    first = -1;
    while (cyc - t_fall < len) begin
      @(negedge clk);
      if (frame_err && first < 0) first = cyc - t_fall;
    end
    if (chk_win) begin
      check({tag, ":err_seen"}, first >= 0, 1'b1);
      check({tag, ":err_not_early"}, first >= TB_TO - 5, 1'b1);
      check({tag, ":err_not_late"}, first <= TB_TO + 10, 1'b1);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check({tag, ":outputs_during_reset"}, {key_in, key_p, key_ext, key_rel, frame_err}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check({tag, ":outputs_after_reset"}, {key_in, key_p, key_ext, key_rel, frame_err}, 0);
    model_reset();
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (10) @(negedge clk);
    check({tag, ":event_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:ev%0d_kind", tag, i), int'(got_q[i].kind), int'(exp_q[i].kind));
      check($sformatf("%s:ev%0d_key_in", tag, i), got_q[i].code, exp_q[i].code);
      check($sformatf("%s:ev%0d_key_ext", tag, i), got_q[i].ext, exp_q[i].ext);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by a randomized one
  // ---------------------------------------------------------------------------
  initial begin
    int makes, rels;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset:outputs_during_reset", {key_in, key_p, key_ext, key_rel, frame_err}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("reset:outputs_after_reset", {key_in, key_p, key_ext, key_rel, frame_err}, 0);

    // 0x6B at 12.5 kHz (80 us bit period), with strobe latency checked.
    send_frame(8'h6b, 0, 0, 2000, 1);
    model_byte(8'h6b);
    compare_events("left_key");

    // E0 74 make, then E0 F0 74 break.
    send_key(8'hE0, 20);
    send_key(8'h74, 20);
    send_key(8'hE0, 20);
    send_key(8'hF0, 20);
    send_key(8'h74, 20);
    compare_events("ext_make_break");
    check("ext_make_break:key_in_held", key_in, 8'h74);
    check("ext_make_break:key_ext_held", key_ext, 1'b1);

    // Parity error, then the same code sent correctly.
    send_frame(8'h1c, 1, 0, 20, 0);
    model_err();
    send_key(8'h1c, 20);
    compare_events("parity_err");

    // Stop-bit error.
    send_frame(8'h29, 0, 1, 20, 0);
    model_err();
    compare_events("stop_err");

    // Timeout after 4 data bits, with an E0 prefix pending that must be dropped.
    send_key(8'hE0, 20);
    send_partial(8'h52, 4, 20);
    stall(TB_TO * 12 / 10, 1, "timeout");
    model_timeout();
    send_key(8'h29, 20);
    compare_events("timeout");
    check("timeout:key_ext_after", key_ext, 1'b0);

    // Reset discards a pending break prefix.
    send_key(8'hF0, 20);
    exp_q.delete();
    pulse_reset("reset_prefix");
    send_key(8'h29, 20);
    compare_events("reset_prefix");

    // Reset in the middle of 0x74; the trailing bits then look like a new
    // frame start (bit 7 is 0) which can only end by timeout.
    send_key(8'hE0, 20);
    send_partial(8'h74, 5, 20);
    exp_q.delete();
    pulse_reset("reset_mid_frame");
    send_bit(1'b1, 20);
    send_bit(1'b1, 20);
    send_bit(1'b0, 20);
    send_bit(1'b1, 20);
    send_bit(1'b1, 20);
    stall(TB_TO + 300, 0, "reset_tail");
    model_timeout();
    send_key(8'h74, 20);
    compare_events("reset_mid_frame");

    // Typematic repeats: 74 74 74 F0 74 74.
    pulse_reset("typematic");
    send_key(8'h74, 20);
    send_key(8'h74, 20);
    send_key(8'h74, 20);
    send_key(8'hF0, 20);
    send_key(8'h74, 20);
    send_key(8'h74, 20);
    repeat (10) @(negedge clk);
    makes = 0;
    rels  = 0;
    foreach (got_q[i]) begin
      if (got_q[i].kind == EV_MAKE) makes++;
      if (got_q[i].kind == EV_REL)  rels++;
    end
    check("typematic:key_p_count", makes, EXP_TYPEMATIC_MAKES);
    check("typematic:key_rel_count", rels, 1);
    compare_events("typematic");

    // Randomized keystrokes with occasional corrupted frames.
    for (int i = 0; i < 14; i++) begin
      logic [7:0] code;
      logic [7:0] junk;
      int         half;
      code = pool[$urandom_range(0, 5)];
      junk = 8'($urandom);
      half = $urandom_range(15, 25);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) send_frame(junk, 1, 0, half, 0);
        else                           send_frame(junk, 0, 1, half, 0);
        model_err();
      end
      if ($urandom_range(0, 1) == 1) send_key(8'hE0, half);
      if ($urandom_range(0, 2) == 0) send_key(8'hF0, half);
      send_key(code, half);
    end
    compare_events("random");

    check("strobe_overlap_cycles", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
